nios_hello_pio_out: RTL and testbench

//  Avalon-MM slave output PIO: the write-side counterpart of the system's input PIO.

---
 rtl/nios_hello_pio_out.sv | 53 +++++
 tb/tb_nios_hello_pio_out.sv | 117 +++++++++++
 2 files changed

// File: rtl/nios_hello_pio_out.sv
// nios_hello_pio_out: Avalon-MM output PIO with a one-shot pulse register driving out_port.
// Define NIOS_HELLO_PIO_OUT_BIT_SETCLR_EN to enable atomic bit set (addr2) / clear (addr3).
module nios_hello_pio_out #(
  parameter int                    DATA_WIDTH   = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES - 1);
  logic [DATA_WIDTH-1:0] r_data, r_mask, w_wd, w_rd;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_rd;
  logic                  w_wr, w_pulse_wr, w_expired, w_unused;
  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[DATA_WIDTH-1:0];
  assign w_pulse_wr = w_wr && address == 2'd1 && |w_wd;
  assign w_expired  = r_cnt == '0;
  assign w_rd       = address == 2'd0 ? r_data : address == 2'd1 ? r_mask : '0;
  assign w_unused   = &{1'b0, writedata};
  always_ff @(posedge clk or posedge reset)
    if (reset) r_data <= RESET_VALUE;
    else if (w_wr && address == 2'd0) r_data <= w_wd;
`ifdef NIOS_HELLO_PIO_OUT_BIT_SETCLR_EN
    else if (w_wr && address == 2'd2) r_data <= r_data | w_wd;
    else if (w_wr && address == 2'd3) r_data <= r_data & ~w_wd;
`endif
  // A write landing on the expiry edge replaces the dying mask instead of extending it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else if (w_pulse_wr) begin
      r_mask <= w_expired ? w_wd : r_mask | w_wd;
      r_cnt  <= RELOAD;
    end else if (|r_mask) begin
      r_mask <= w_expired ? '0 : r_mask;
      r_cnt  <= w_expired ? r_cnt : r_cnt - 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rd <= '0;
    else r_rd <= 32'(w_rd);
  assign readdata = r_rd;
  assign out_port = r_data | r_mask;
endmodule

// File: tb/tb_nios_hello_pio_out.sv
// tb_nios_hello_pio_out: directed self-checking bench, DATA_WIDTH=6, RESET_VALUE=0, PULSE_CYCLES=4.
module tb_nios_hello_pio_out;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [5:0]  out_port;
  int          errors = 0, checks = 0;
  nios_hello_pio_out #(.DATA_WIDTH(6), .RESET_VALUE(6'h00), .PULSE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Called at a negedge; the write is taken on the next posedge and this returns at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    @(negedge clk);
    chipselect = 1'b0;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask
  task automatic hold_out(input string tag, input int n, input logic [5:0] exp);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk(tag, 32'(out_port), 32'(exp));
    end
  endtask
  initial begin
    logic [5:0] exp_set, exp_clr;
`ifdef NIOS_HELLO_PIO_OUT_BIT_SETCLR_EN
    exp_set = 6'h3F; exp_clr = 6'h3C;
`else
    exp_set = 6'h0F; exp_clr = 6'h0F;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_rd", readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    wr(2'd0, 32'hFFFF_FF2A);
    chk("data_out", 32'(out_port), 32'h2A);
    chk("data_rd_old", readdata, 32'h0);
    @(negedge clk);
    chk("data_rd", readdata, 32'h0000_002A);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(out_port), 32'h0);
    chk("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr(2'd1, 32'h05);
    chk("pulse_rd_old", readdata, 32'h0);
    hold_out("pulse_hi", 4, 6'h05);
    chk("pulse_rd_hi", readdata, 32'h05);
    @(negedge clk);
    chk("pulse_lo", 32'(out_port), 32'h0);
    chk("pulse_rd_hold", readdata, 32'h05);
    @(negedge clk);
    chk("pulse_rd_lo", readdata, 32'h0);
    wr(2'd1, 32'h0);
    chk("pulse_zero_noop", 32'(out_port), 32'h0);
    wr(2'd1, 32'h01);
    chk("retrig_first", 32'(out_port), 32'h01);
    repeat (2) @(negedge clk);
    wr(2'd1, 32'h02);
    hold_out("retrig_hi", 4, 6'h03);
    @(negedge clk);
    chk("retrig_lo", 32'(out_port), 32'h0);
    @(negedge clk);
    wr(2'd1, 32'h01);
    hold_out("exp_first", 4, 6'h01);
    wr(2'd1, 32'h02);
    hold_out("exp_write_wins", 4, 6'h02);
    @(negedge clk);
    chk("exp_lo", 32'(out_port), 32'h0);
    wr(2'd1, 32'h3F);
    chk("midrst_hi", 32'(out_port), 32'h3F);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out", 32'(out_port), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hold_out("midrst_after", 6, 6'h00);
    rd("midrst_mask", 2'd1, 32'h0);
    wr(2'd0, 32'h0F);
    wr(2'd1, 32'h10);
    hold_out("pulse_over_data", 4, 6'h1F);
    @(negedge clk);
    chk("data_after_pulse", 32'(out_port), 32'h0F);
    wr(2'd2, 32'h30);
    chk("set_out", 32'(out_port), 32'(exp_set));
    wr(2'd3, 32'h03);
    chk("clr_out", 32'(out_port), 32'(exp_clr));
    rd("addr2_rd", 2'd2, 32'h0);
    rd("addr3_rd", 2'd3, 32'h0);
    rd("addr0_rd", 2'd0, 32'(exp_clr));
    address = 2'd0; writedata = 32'h15; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    chk("nocs_ignored", 32'(out_port), 32'(exp_clr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
